// File: rtl/sccb_slave_regif_if.sv
// Register-port bundle between the SCCB target and the register file it serves.
// The target side (master modport) drives address, write data and strobes.
interface sccb_slave_regif_if;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [7:0]  reg_rdata;
  logic        busy;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_wr_en,
    output reg_rd_en,
    output busy,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_wr_en,
    input  reg_rd_en,
    input  busy,
    output reg_rdata
  );
endinterface

// File: rtl/sccb_slave_regif.sv
// SCCB/I2C target with 16-bit sub-address and 8-bit data, turning bus transactions
// into single-cycle register read/write strobes on an oversampled SCL/SDA.
module sccb_slave_regif #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b1010000,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scl,
  inout  wire                sda,
  sccb_slave_regif_if.master regif
);

  localparam logic [2:0] FiltMax = 3'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    StIdle, StDevAddr, StDevAck, StAddrH, StAddrHAck, StAddrL, StAddrLAck,
    StWrData, StWrAck, StRdData, StRdAck, StIgnore
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic [2:0] scl_cnt_q, sda_cnt_q;
  logic       scl_f_q, sda_f_q, scl_p_q, sda_p_q;

  // Synchronise, then only accept a new level after FILTER_LEN identical samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_p_q    <= scl_f_q;
      sda_p_q    <= sda_f_q;
      if (scl_sync_q[1] == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == FiltMax) begin
        scl_f_q   <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 3'd1;
      end
      if (sda_sync_q[1] == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == FiltMax) begin
        sda_f_q   <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 3'd1;
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        ack_ph_q, rw_q, sda_oe_q, busy_q;
  logic [15:0] reg_addr_q;
  logic [7:0]  reg_wdata_q;
  logic        wr_en_q, rd_en_q, inc_q, rd_req_q, load_q;
  logic [7:0]  rx_byte;

  assign rx_byte = {shift_q[6:0], sda_f_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ack_ph_q    <= 1'b0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      inc_q       <= 1'b0;
      rd_req_q    <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      inc_q    <= 1'b0;
      rd_req_q <= 1'b0;
      load_q   <= 1'b0;
      if (inc_q) reg_addr_q <= reg_addr_q + 16'd1;
      // Burst reads strobe one cycle after the pointer bump so the new address is seen.
      if (rd_req_q) begin
        rd_en_q <= 1'b1;
        load_q  <= 1'b1;
      end
      if (load_q) shift_q <= regif.reg_rdata;

      if (start_det || stop_det) begin
        state_q   <= start_det ? StDevAddr : StIdle;
        bit_cnt_q <= '0;
        ack_ph_q  <= 1'b0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          StDevAddr, StAddrH, StAddrL, StWrData: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              ack_ph_q  <= 1'b0;
              if (bit_cnt_q == 3'd7) begin
                case (state_q)
                  StDevAddr: begin
                    if (rx_byte[7:1] == SLAVE_ADDR) begin
                      busy_q  <= 1'b1;
                      rw_q    <= rx_byte[0];
                      state_q <= StDevAck;
                    end else begin
                      state_q <= StIgnore;
                    end
                  end
                  StAddrH: begin
                    reg_addr_q[15:8] <= rx_byte;
                    state_q          <= StAddrHAck;
                  end
                  StAddrL: begin
                    reg_addr_q[7:0] <= rx_byte;
                    state_q         <= StAddrLAck;
                  end
                  default: begin
                    reg_wdata_q <= rx_byte;
                    wr_en_q     <= 1'b1;
                    inc_q       <= 1'b1;
                    state_q     <= StWrAck;
                  end
                endcase
              end
            end
          end
          StDevAck, StAddrHAck, StAddrLAck, StWrAck: begin
            if (scl_fall) begin
              if (!ack_ph_q) begin
                ack_ph_q <= 1'b1;
                sda_oe_q <= 1'b1;
                if (state_q == StDevAck && rw_q) begin
                  rd_en_q <= 1'b1;
                  load_q  <= 1'b1;
                end
              end else begin
                ack_ph_q  <= 1'b0;
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                case (state_q)
                  StDevAck: begin
                    if (rw_q) begin
                      state_q  <= StRdData;
                      sda_oe_q <= ~shift_q[7];
                    end else begin
                      state_q <= StAddrH;
                    end
                  end
                  StAddrHAck: state_q <= StAddrL;
                  default:    state_q <= StWrData;
                endcase
              end
            end
          end
          StRdData: begin
            if (scl_fall) sda_oe_q <= ~shift_q[7];
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q  <= StRdAck;
                ack_ph_q <= 1'b0;
              end
            end
          end
          StRdAck: begin
            if (scl_fall) begin
              if (!ack_ph_q) begin
                sda_oe_q <= 1'b0;
                ack_ph_q <= 1'b1;
              end else begin
                ack_ph_q  <= 1'b0;
                bit_cnt_q <= '0;
                sda_oe_q  <= ~shift_q[7];
                state_q   <= StRdData;
              end
            end
            if (scl_rise && ack_ph_q) begin
              if (sda_f_q) begin
                state_q  <= StIgnore;
                busy_q   <= 1'b0;
                ack_ph_q <= 1'b0;
              end else begin
                inc_q    <= 1'b1;
                rd_req_q <= 1'b1;
              end
            end
          end
          default: begin
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda             = sda_oe_q ? 1'b0 : 1'bz;
  assign regif.reg_addr  = reg_addr_q;
  assign regif.reg_wdata = reg_wdata_q;
  assign regif.reg_wr_en = wr_en_q;
  assign regif.reg_rd_en = rd_en_q;
  assign regif.busy      = busy_q;

endmodule

// File: tb/tb_sccb_slave_regif.sv
// Bench for sccb_slave_regif: bit-banged SCCB master, byte-level transaction model
// with a register-file image, directed corner cases plus randomized transfers.
module tb_sccb_slave_regif;

  localparam logic [6:0] Dev = 7'h50;
  localparam int         Q   = 10;

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic scl      = 1'b1;
  logic m_sda_oe = 1'b0;
  wire  sda;

  logic [7:0]  rmem [256];
  logic [7:0]  tx_q [$];
  logic [23:0] wr_q [$];
  logic [15:0] rd_q [$];
  int          glitch_at = -1;
  int          n_cmp = 0;
  int          n_bad = 0;

  sccb_slave_regif_if rif();
  assign rif.reg_rdata = rmem[rif.reg_addr[7:0]];

  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;

  sccb_slave_regif #(
    .SLAVE_ADDR (Dev),
    .FILTER_LEN (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl   (scl),
    .sda   (sda),
    .regif (rif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rif.reg_wr_en) wr_q.push_back({rif.reg_addr, rif.reg_wdata});
    if (rif.reg_rd_en) rd_q.push_back(rif.reg_addr);
    if (rif.reg_wr_en || rif.reg_rd_en)
      check("strobe_excl", 32'(rif.reg_wr_en & rif.reg_rd_en), 32'd0);
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    m_sda_oe = ~b;
    clks(Q);
    scl = 1'b1;
    clks(2 * Q);
    scl = 1'b0;
    clks(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda_oe = 1'b0;
    clks(Q);
    scl = 1'b1;
    clks(Q);
    b = sda;
    clks(Q);
    scl = 1'b0;
    clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, input int glitch_after, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      if (8 - i == glitch_after) begin
        scl = 1'b1;
        clks(1);
        scl = 1'b0;
        clks(Q);
      end
    end
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      v[i] = b;
    end
  endtask

  task automatic start_cond();
    m_sda_oe = 1'b0;
    clks(Q);
    scl = 1'b1;
    clks(Q);
    m_sda_oe = 1'b1;
    clks(Q);
    scl = 1'b0;
    clks(Q);
  endtask

  task automatic stop_cond();
    m_sda_oe = 1'b1;
    clks(Q);
    scl = 1'b1;
    clks(Q);
    m_sda_oe = 1'b0;
    clks(Q);
  endtask

  // Pointer write then tx_q as data; expected strobes follow the auto-incrementing pointer.
  task automatic do_write(input string tag, input logic [6:0] dev, input logic [15:0] ptr,
                          input bit fin);
    logic        ack;
    logic [15:0] p;
    bit          hit;
    hit = (dev == Dev);
    wr_q.delete();
    start_cond();
    send_byte({dev, 1'b0}, -1, ack);
    check({tag, "_dev_ack"}, 32'(ack), 32'(!hit));
    send_byte(ptr[15:8], -1, ack);
    check({tag, "_ah_ack"}, 32'(ack), 32'(!hit));
    send_byte(ptr[7:0], -1, ack);
    check({tag, "_al_ack"}, 32'(ack), 32'(!hit));
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], glitch_at, ack);
      check({tag, "_d_ack"}, 32'(ack), 32'(!hit));
    end
    check({tag, "_busy"}, 32'(rif.busy), 32'(hit));
    if (fin) begin
      stop_cond();
      clks(8);
      check({tag, "_busy_stop"}, 32'(rif.busy), 32'd0);
    end
    check({tag, "_wr_cnt"}, 32'(wr_q.size()), 32'(hit ? tx_q.size() : 0));
    p = ptr;
    for (int i = 0; i < wr_q.size() && i < tx_q.size(); i++) begin
      check({tag, "_wr"}, 32'(wr_q[i]), 32'({p, tx_q[i]}));
      p = p + 16'd1;
    end
  endtask

  task automatic do_read(input string tag, input logic [15:0] ptr, input int n);
    logic        ack;
    logic [7:0]  v;
    logic [15:0] p;
    tx_q.delete();
    do_write(tag, Dev, ptr, 1'b0);
    rd_q.delete();
    start_cond();
    send_byte({Dev, 1'b1}, -1, ack);
    check({tag, "_rdev_ack"}, 32'(ack), 32'd0);
    p = ptr;
    for (int i = 0; i < n; i++) begin
      recv_byte(v);
      check({tag, "_rdata"}, 32'(v), 32'(rmem[p[7:0]]));
      send_bit(i == n - 1);
      p = p + 16'd1;
    end
    m_sda_oe = 1'b0;
    clks(2);
    check({tag, "_sda_rel"}, 32'(sda), 32'd1);
    check({tag, "_busy_nack"}, 32'(rif.busy), 32'd0);
    stop_cond();
    clks(8);
    check({tag, "_rd_cnt"}, 32'(rd_q.size()), 32'(n));
    for (int i = 0; i < rd_q.size() && i < n; i++)
      check({tag, "_rd_addr"}, 32'(rd_q[i]), 32'(ptr + 16'(i)));
  endtask

  initial begin
    logic        ack;
    logic [6:0]  dev;
    logic [15:0] ptr;
    for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom);

    #2 rst_n = 1'b0;
    clks(3);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_addr", 32'(rif.reg_addr), 32'd0);
    check("rst_wdata", 32'(rif.reg_wdata), 32'd0);
    check("rst_wr_en", 32'(rif.reg_wr_en), 32'd0);
    check("rst_rd_en", 32'(rif.reg_rd_en), 32'd0);
    check("rst_busy", 32'(rif.busy), 32'd0);
    rst_n = 1'b1;
    clks(5);

    tx_q = '{8'h82};
    do_write("wr1", Dev, 16'h3008, 1'b1);

    tx_q = '{8'h11, 8'h22};
    do_write("burst", Dev, 16'hFFFF, 1'b1);

    tx_q = '{8'h55};
    do_write("bad", 7'h51, 16'h1234, 1'b1);
    tx_q = '{8'h66};
    do_write("good", Dev, 16'h0042, 1'b1);

    rmem[8'h34] = 8'h5A;
    rmem[8'h35] = 8'hC3;
    do_read("rd", 16'h1234, 2);

    // STOP after half a data byte: pointer lands, no write strobe.
    wr_q.delete();
    start_cond();
    send_byte({Dev, 1'b0}, -1, ack);
    send_byte(8'h01, -1, ack);
    send_byte(8'h00, -1, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    stop_cond();
    clks(8);
    check("part_wr_cnt", 32'(wr_q.size()), 32'd0);
    check("part_busy", 32'(rif.busy), 32'd0);
    check("part_sda", 32'(sda), 32'd1);
    check("part_addr", 32'(rif.reg_addr), 32'h0100);

    glitch_at = 4;
    tx_q = '{8'hA5};
    do_write("glitch", Dev, 16'h2020, 1'b1);
    glitch_at = -1;

    // Reset asserted while the target is driving the ACK of the high pointer byte.
    start_cond();
    send_byte({Dev, 1'b0}, -1, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'hAB >> i));
    m_sda_oe = 1'b0;
    clks(2);
    check("ack_drive", 32'(sda), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_ack_sda", 32'(sda), 32'd1);
    check("rst_ack_addr", 32'(rif.reg_addr), 32'd0);
    check("rst_ack_busy", 32'(rif.busy), 32'd0);
    clks(3);
    rst_n = 1'b1;
    clks(3);
    scl = 1'b1;
    clks(2 * Q);

    for (int k = 0; k < 6; k++) begin
      dev = Dev;
      if ($urandom_range(0, 3) == 0) dev = Dev ^ 7'(1 + $urandom_range(0, 126));
      ptr = ($urandom_range(0, 2) == 0) ? 16'hFFFE : 16'($urandom);
      tx_q.delete();
      repeat ($urandom_range(1, 3)) tx_q.push_back(8'($urandom));
      do_write("rnd_wr", dev, ptr, 1'b1);
      do_read("rnd_rd", 16'($urandom), int'($urandom_range(1, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
